uart_tx_fifo_ctrl: RTL

Byte-buffering launch controller directly upstream of uart_tx. Accepts bytes from the host at any rate into a DEPTH-entry FIFO. Drains the FIFO by issuing one-cycle i_tx_dv pulses to uart_tx, then waits for that frame to complete before launching the next byte. Bytes that arrive while the FIFO is full are dropped and flagged.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_sync_fifo.sv | 99 +++++++++
 rtl/uart_tx_fifo_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: launch FSM states, byte width, gap counter sizing.
package uart_pkg;

  localparam int unsigned BYTE_W = 32'd8;

  // Launch FSM states; GAP is only reachable when the inter-frame gap is built in.
  typedef enum logic [1:0] {
    SETTLE    = 2'd0,
    IDLE      = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } tx_state_e;

  // Bits needed for a down-counter holding clks_per_bit*gap_bits-1 .. 0.
  function automatic int unsigned gap_cnt_width(input int unsigned clks_per_bit,
                                                input int unsigned gap_bits);
    int unsigned n;
    n = clks_per_bit * gap_bits;
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Register-based synchronous FIFO with occupancy count, registered full/empty
// and a sticky overflow flag. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; otherwise it is dropped and flagged.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 32'd16,
  parameter int unsigned WIDTH = BYTE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  input  logic                   clr_ovf,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 32'd1;
  localparam logic [AW-1:0] PTR_ONE = AW'(32'd1);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_s;
  logic             full_r;
  logic             empty_r;
  logic             ovf_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             drop_s;

  // Qualify push/pop and work out the next occupancy.
  always_comb begin
    pop_ok_s  = pop & ~empty_r;
    push_ok_s = push & (~full_r | pop_ok_s);
    drop_s    = push & ~push_ok_s;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // Storage array; cleared on reset so no stale data survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, count and the full/empty flags taken from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_s;
      full_r  <= (count_s == CNT_FULL);
      empty_r <= (count_s == CNT_ZERO);
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (clr_ovf) begin
      ovf_r <= 1'b0;
    end
  end

  assign rd_data  = mem_r[rd_ptr_r];
  assign full     = full_r;
  assign empty    = empty_r;
  assign count    = count_r;
  assign overflow = ovf_r;

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Byte-buffering launch controller in front of uart_tx. Bytes queue in a
// FIFO; the FSM launches one byte per frame with a single-cycle o_tx_dv and
// waits for o_tx_done before the next. Define UART_TX_FIFO_GAP_EN to insert
// GAP_BITS idle bit-times between frames.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH        = 32'd16,
  parameter int unsigned CLKS_PER_BIT = 32'd87,
  parameter int unsigned GAP_BITS     = 32'd1
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_wr_en,
  input  logic [BYTE_W-1:0]      i_wr_byte,
  input  logic                   i_clr_ovf,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow,
  output logic                   o_tx_dv,
  output logic [BYTE_W-1:0]      o_tx_byte,
  input  logic                   i_tx_active,
  input  logic                   i_tx_done
);

  // Reject configurations the FIFO pointers and gap counter cannot handle.
  if ((DEPTH < 32'd2) || ((DEPTH & (DEPTH - 32'd1)) != 32'd0)) begin : g_bad_depth
    $error("uart_tx_fifo_ctrl: DEPTH must be a power of two and at least 2");
  end
  if ((CLKS_PER_BIT < 32'd1) || (GAP_BITS < 32'd1)) begin : g_bad_timing
    $error("uart_tx_fifo_ctrl: CLKS_PER_BIT and GAP_BITS must be at least 1");
  end

  tx_state_e         state_r;
  tx_state_e         state_s;
  logic              pop_s;
  logic [BYTE_W-1:0] head_s;
  logic              tx_dv_r;
  logic [BYTE_W-1:0] tx_byte_r;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk      (i_clock),
    .rst      (i_reset),
    .push     (i_wr_en),
    .wr_data  (i_wr_byte),
    .pop      (pop_s),
    .rd_data  (head_s),
    .clr_ovf  (i_clr_ovf),
    .full     (o_full),
    .empty    (o_empty),
    .count    (o_count),
    .overflow (o_overflow)
  );

`ifdef UART_TX_FIFO_GAP_EN
  localparam int unsigned GW = gap_cnt_width(CLKS_PER_BIT, GAP_BITS);
  localparam logic [GW-1:0] GAP_LOAD = GW'(CLKS_PER_BIT * GAP_BITS - 32'd1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(32'd1);
  localparam logic [GW-1:0] GAP_ZERO = GW'(32'd0);

  logic [GW-1:0] gap_cnt_r;

  // Inter-frame gap counter: loaded when the frame completes, counts down in GAP.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      gap_cnt_r <= GAP_ZERO;
    end else if ((state_r == WAIT_DONE) && i_tx_done) begin
      gap_cnt_r <= GAP_LOAD;
    end else if ((state_r == GAP) && (gap_cnt_r != GAP_ZERO)) begin
      gap_cnt_r <= gap_cnt_r - GAP_ONE;
    end
  end
`endif

  // Launch FSM state register; reset lands in SETTLE as uart_tx is not reset.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_r <= SETTLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and pop decision.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    case (state_r)
      SETTLE: begin
        if (!i_tx_active) begin
          state_s = IDLE;
        end else begin
          state_s = SETTLE;
        end
      end
      IDLE: begin
        if (!o_empty && !i_tx_active) begin
          pop_s   = 1'b1;
          state_s = WAIT_DONE;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_DONE: begin
        if (i_tx_done) begin
`ifdef UART_TX_FIFO_GAP_EN
          state_s = GAP;
`else
          state_s = SETTLE;
`endif
        end else begin
          state_s = WAIT_DONE;
        end
      end
`ifdef UART_TX_FIFO_GAP_EN
      GAP: begin
        if (gap_cnt_r == GAP_ZERO) begin
          state_s = SETTLE;
        end else begin
          state_s = GAP;
        end
      end
`endif
      default: begin
        state_s = SETTLE;
      end
    endcase
  end

  // Registered launch outputs: one-cycle strobe, byte held after the strobe.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tx_dv_r   <= 1'b0;
      tx_byte_r <= 8'h00;
    end else begin
      tx_dv_r <= pop_s;
      if (pop_s) begin
        tx_byte_r <= head_s;
      end
    end
  end

  assign o_tx_dv   = tx_dv_r;
  assign o_tx_byte = tx_byte_r;

endmodule
